// File: rtl/postmortem_ctrl.sv
// Post-mortem capture controller: records a sample stream into an external
// circular RAM until a configurable number of post-trigger samples has been
// stored. It then freezes the buffer and can read it out in chronological order.
// Optional build macro: PM_TRIG_SYNC_EN adds a 2-flop synchronizer and a
// registered rising-edge detector on i_trig.
module postmortem_ctrl #(
    parameter int DWIDTH    = 32,
    parameter int RAM_DEPTH = 50000,
    localparam int AW       = $clog2(RAM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_arm,
    input  logic              i_trig,
    input  logic              i_rd_req,
    input  logic              i_sample_valid,
    input  logic [DWIDTH-1:0] i_sample,
    input  logic [AW-1:0]     i_post_len,
    output logic [AW-1:0]     o_wr_addr,
    output logic              o_wr_ce,
    output logic              o_wr_we,
    output logic [DWIDTH-1:0] o_wr_din,
    output logic [AW-1:0]     o_rd_addr,
    output logic              o_rd_ce,
    input  logic [DWIDTH-1:0] i_rd_dout,
    output logic              o_rd_valid,
    output logic [DWIDTH-1:0] o_rd_data,
    output logic              o_rd_last,
    input  logic              i_rd_ready,
    output logic [2:0]        o_state,
    output logic              o_frozen,
    output logic              o_wrapped,
    output logic [AW-1:0]     o_trig_addr,
    output logic [AW:0]       o_count
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArmed   = 3'd1,
        StPost    = 3'd2,
        StFrozen  = 3'd3,
        StRdIssue = 3'd4,
        StRdWait  = 3'd5,
        StRdOut   = 3'd6
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(RAM_DEPTH);

    state_e              state_q;
    logic [AW-1:0]       wr_ptr_q;
    logic [AW:0]         count_q;
    logic                wrapped_q;
    logic [AW-1:0]       trig_addr_q;
    logic [AW-1:0]       post_len_q;
    logic [AW-1:0]       post_cnt_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [AW:0]         rd_left_q;
    logic [DWIDTH-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                rd_last_q;
    logic                rd_ce_q;
    logic                frozen_q;

    logic                trig_evt;
    logic                wr_en;
    logic [AW-1:0]       wr_ptr_nxt;
    logic [AW-1:0]       rd_ptr_nxt;
    logic [AW-1:0]       post_len_clamped;
    logic [AW-1:0]       post_cnt_inc;

`ifdef PM_TRIG_SYNC_EN
    logic sync1_q, sync2_q, sync3_q, trig_pulse_q;

    // Synchronize i_trig and turn its rising edge into a registered one-cycle pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            trig_pulse_q <= 1'b0;
        end else begin
            sync1_q      <= i_trig;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            trig_pulse_q <= sync2_q & ~sync3_q;
        end
    end

    assign trig_evt = trig_pulse_q;
`else
    assign trig_evt = i_trig;
`endif

    // Write port passes samples straight through while capturing
    always_comb begin
        wr_en            = ((state_q == StArmed) || (state_q == StPost)) && i_sample_valid;
        wr_ptr_nxt       = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_nxt       = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
        post_len_clamped = (i_post_len > LAST_ADDR) ? LAST_ADDR : i_post_len;
        post_cnt_inc     = post_cnt_q + 1'b1;
    end

    assign o_wr_ce     = wr_en;
    assign o_wr_we     = wr_en;
    assign o_wr_addr   = wr_ptr_q;
    assign o_wr_din    = i_sample;
    assign o_rd_addr   = rd_ptr_q;
    assign o_rd_ce     = rd_ce_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_data   = rd_data_q;
    assign o_rd_last   = rd_last_q;
    assign o_state     = state_q;
    assign o_frozen    = frozen_q;
    assign o_wrapped   = wrapped_q;
    assign o_trig_addr = trig_addr_q;
    assign o_count     = count_q;

    // Capture / freeze / readout state machine with its registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            trig_addr_q <= '0;
            post_len_q  <= '0;
            post_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            rd_left_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_ce_q     <= 1'b0;
            frozen_q    <= 1'b0;
        end else begin
            rd_ce_q <= 1'b0;

            if (wr_en) begin
                wr_ptr_q <= wr_ptr_nxt;
                if (wr_ptr_q == LAST_ADDR) wrapped_q <= 1'b1;
                if (count_q != DEPTH_CNT) count_q <= count_q + 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (i_arm) begin
                        state_q   <= StArmed;
                        wr_ptr_q  <= '0;
                        count_q   <= '0;
                        wrapped_q <= 1'b0;
                    end
                end
                StArmed: begin
                    if (trig_evt) begin
                        trig_addr_q <= wr_ptr_q;
                        post_len_q  <= post_len_clamped;
                        post_cnt_q  <= '0;
                        // Zero post length freezes right after the trigger cycle
                        if (post_len_clamped == '0) begin
                            state_q  <= StFrozen;
                            frozen_q <= 1'b1;
                        end else begin
                            state_q  <= StPost;
                        end
                    end
                end
                StPost: begin
                    if (i_sample_valid) begin
                        post_cnt_q <= post_cnt_inc;
                        if (post_cnt_inc == post_len_q) begin
                            state_q  <= StFrozen;
                            frozen_q <= 1'b1;
                        end
                    end
                end
                StFrozen: begin
                    if (i_arm) begin
                        state_q   <= StArmed;
                        frozen_q  <= 1'b0;
                        wr_ptr_q  <= '0;
                        count_q   <= '0;
                        wrapped_q <= 1'b0;
                    end else if (i_rd_req && (count_q != '0)) begin
                        // Oldest word sits at the write pointer once the buffer has wrapped
                        rd_ptr_q  <= wrapped_q ? wr_ptr_q : '0;
                        rd_left_q <= count_q;
                        rd_ce_q   <= 1'b1;
                        frozen_q  <= 1'b0;
                        state_q   <= StRdIssue;
                    end
                end
                StRdIssue: begin
                    state_q <= StRdWait;
                end
                StRdWait: begin
                    rd_data_q  <= i_rd_dout;
                    rd_valid_q <= 1'b1;
                    rd_last_q  <= (rd_left_q == (AW + 1)'(1));
                    state_q    <= StRdOut;
                end
                StRdOut: begin
                    if (i_rd_ready) begin
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                        rd_ptr_q   <= rd_ptr_nxt;
                        rd_left_q  <= rd_left_q - 1'b1;
                        if (rd_left_q == (AW + 1)'(1)) begin
                            state_q  <= StFrozen;
                            frozen_q <= 1'b1;
                        end else begin
                            rd_ce_q  <= 1'b1;
                            state_q  <= StRdIssue;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_postmortem_ctrl.sv
// Bench for postmortem_ctrl (RAM_DEPTH=16, DWIDTH=32, trigger sync disabled).
// A sample-history model predicts write traffic, status and the readout stream.
module tb_postmortem_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_arm = 1'b0, i_trig = 1'b0, i_rd_req = 1'b0;
    logic          i_sample_valid = 1'b0;
    logic [DW-1:0] i_sample = '0;
    logic [AW-1:0] i_post_len = '0;
    logic [AW-1:0] o_wr_addr, o_rd_addr, o_trig_addr;
    logic          o_wr_ce, o_wr_we, o_rd_ce, o_rd_valid, o_rd_last, o_frozen, o_wrapped;
    logic [DW-1:0] o_wr_din, o_rd_data, i_rd_dout;
    logic          i_rd_ready = 1'b0;
    logic [2:0]    o_state;
    logic [AW:0]   o_count;

    postmortem_ctrl #(.DWIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_arm(i_arm), .i_trig(i_trig), .i_rd_req(i_rd_req),
        .i_sample_valid(i_sample_valid), .i_sample(i_sample), .i_post_len(i_post_len),
        .o_wr_addr(o_wr_addr), .o_wr_ce(o_wr_ce), .o_wr_we(o_wr_we), .o_wr_din(o_wr_din),
        .o_rd_addr(o_rd_addr), .o_rd_ce(o_rd_ce), .i_rd_dout(i_rd_dout),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
        .i_rd_ready(i_rd_ready), .o_state(o_state), .o_frozen(o_frozen),
        .o_wrapped(o_wrapped), .o_trig_addr(o_trig_addr), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    // Single-port-per-side RAM with one cycle read latency
    logic [DW-1:0] ram [DEPTH];
    always @(posedge i_clk) begin
        if (o_wr_ce && o_wr_we) ram[o_wr_addr] <= o_wr_din;
        if (o_rd_ce) i_rd_dout <= ram[o_rd_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model state
    logic [DW-1:0] hist[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] rcv[$];
    int            total = 0, post_rem = 0, exp_trig = 0, rd_start = 0, rd_issued = 0;
    bit            capturing = 0, triggered = 0, arm_pending = 0, rd_active = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;

    // Compare DUT against the model every cycle, then advance the model
    always @(negedge i_clk) begin
        bit exp_we;
        int idx;
        if (i_rst) begin
            check("rst_state", 64'(o_state), 64'd0);
            check("rst_count", 64'(o_count), 64'd0);
            check("rst_wrapped", 64'(o_wrapped), 64'd0);
            check("rst_trig_addr", 64'(o_trig_addr), 64'd0);
            check("rst_frozen", 64'(o_frozen), 64'd0);
            check("rst_wr_ce", 64'({o_wr_ce, o_wr_we}), 64'd0);
            check("rst_wr_addr", 64'(o_wr_addr), 64'd0);
            check("rst_rd_ctl", 64'({o_rd_ce, o_rd_valid, o_rd_last}), 64'd0);
            check("rst_rd_data", 64'(o_rd_data), 64'd0);
            total = 0; hist.delete(); capturing = 0; triggered = 0;
            arm_pending = 0; rd_active = 0; prev_stall = 0;
        end else begin
            check("count", 64'(o_count), 64'(total >= DEPTH ? DEPTH : total));
            check("wrapped", 64'(o_wrapped), 64'(total >= DEPTH));
            exp_we = capturing && i_sample_valid;
            check("wr_ce", 64'(o_wr_ce), 64'(exp_we));
            check("wr_we", 64'(o_wr_we), 64'(exp_we));
            if (exp_we) begin
                check("wr_addr", 64'(o_wr_addr), 64'(total % DEPTH));
                check("wr_din", 64'(o_wr_din), 64'(i_sample));
            end
            if (triggered) check("trig_addr", 64'(o_trig_addr), 64'(exp_trig));
            if (!rd_active) begin
                check("rd_idle", 64'({o_rd_ce, o_rd_valid}), 64'd0);
            end else begin
                if (o_rd_ce) begin
                    check("rd_addr", 64'(o_rd_addr), 64'((rd_start + rd_issued) % DEPTH));
                    rd_issued++;
                end
                if (prev_stall) begin
                    check("stall_valid", 64'(o_rd_valid), 64'd1);
                    check("stall_data", 64'(o_rd_data), 64'(prev_data));
                end
                prev_stall = 0;
                if (o_rd_valid) begin
                    if (i_rd_ready) begin
                        idx = rcv.size();
                        check("rd_data", 64'(o_rd_data), 64'(exp_rd[idx]));
                        check("rd_last", 64'(o_rd_last), 64'(idx == exp_rd.size() - 1));
                        rcv.push_back(o_rd_data);
                        if (idx == exp_rd.size() - 1) rd_active = 0;
                    end else begin
                        prev_stall = 1;
                        prev_data  = o_rd_data;
                    end
                end
            end
            if (arm_pending && i_arm) begin
                total = 0; hist.delete(); capturing = 1; triggered = 0; arm_pending = 0;
            end else if (capturing) begin
                if (!triggered && i_trig) begin
                    triggered = 1;
                    exp_trig  = total % DEPTH;
                    post_rem  = (int'(i_post_len) > DEPTH - 1) ? DEPTH - 1 : int'(i_post_len);
                    if (post_rem == 0) capturing = 0;
                end else if (triggered && i_sample_valid) begin
                    post_rem--;
                    if (post_rem == 0) capturing = 0;
                end
                if (exp_we) begin
                    hist.push_back(i_sample);
                    if (hist.size() > DEPTH) void'(hist.pop_front());
                    total++;
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic arm();
        i_arm = 1'b1; arm_pending = 1; step(); i_arm = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit trig);
        i_sample = d; i_sample_valid = 1'b1; i_trig = trig;
        step();
        i_sample_valid = 1'b0; i_trig = 1'b0;
    endtask

    task automatic start_readout();
        exp_rd = hist; rcv.delete(); rd_issued = 0;
        rd_start = (total >= DEPTH) ? total % DEPTH : 0;
        rd_active = (hist.size() != 0);
        i_rd_req = 1'b1; step(); i_rd_req = 1'b0;
    endtask

    task automatic run_readout(input bit stall);
        int stall_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            if (!rd_active) break;
            i_rd_ready = !(stall && rcv.size() == 2 && o_rd_valid && stall_cnt < 10);
            if (!i_rd_ready) stall_cnt++;
            step();
        end
        i_rd_ready = 1'b0;
        check("rd_words", 64'(rcv.size()), 64'(exp_rd.size()));
        check("rd_done_state", 64'(o_state), 64'd3);
        if (stall) check("stall_len", 64'(stall_cnt), 64'd10);
    endtask

    initial begin
        step(); step();
        i_rst = 1'b0;
        step();
        check("idle_state", 64'(o_state), 64'd0);

        // Basic capture: trigger on the third of five samples
        i_post_len = 4'd2;
        arm();
        check("armed_state", 64'(o_state), 64'd1);
        for (int k = 1; k <= 5; k++) send(DW'(k), k == 3);
        check("s1_state", 64'(o_state), 64'd3);
        check("s1_frozen", 64'(o_frozen), 64'd1);
        check("s1_trig", 64'(o_trig_addr), 64'd2);
        check("s1_count", 64'(o_count), 64'd5);
        check("s1_wrapped", 64'(o_wrapped), 64'd0);
        start_readout();
        run_readout(1'b0);
        check("s1_first", 64'(rcv[0]), 64'h1);
        check("s1_lastw", 64'(rcv[4]), 64'h5);

        // Wrapped capture
        i_post_len = 4'd3;
        arm();
        for (int k = 'h10; k <= 'h23; k++) send(DW'(k), k == 'h20);
        check("s2_state", 64'(o_state), 64'd3);
        check("s2_trig", 64'(o_trig_addr), 64'd0);
        check("s2_count", 64'(o_count), 64'd16);
        check("s2_wrapped", 64'(o_wrapped), 64'd1);
        start_readout();
        run_readout(1'b0);
        check("s2_first", 64'(rcv[0]), 64'h14);
        check("s2_lastw", 64'(rcv[15]), 64'h23);
        // Re-read the same buffer with a 10-cycle backpressure stall
        start_readout();
        run_readout(1'b1);
        check("s4_first", 64'(rcv[0]), 64'h14);

        // Arm beats read request; empty buffer ignores read request
        i_post_len = 4'd0;
        i_arm = 1'b1; i_rd_req = 1'b1; arm_pending = 1;
        step();
        i_arm = 1'b0; i_rd_req = 1'b0;
        check("arm_wins", 64'(o_state), 64'd1);
        i_trig = 1'b1; step(); i_trig = 1'b0;
        check("empty_frozen", 64'(o_state), 64'd3);
        check("empty_count", 64'(o_count), 64'd0);
        i_rd_req = 1'b1; step(); i_rd_req = 1'b0;
        check("empty_rd_ignored", 64'(o_state), 64'd3);

        // Zero post length, arm ignored while armed, second trigger ignored
        arm();
        send(32'h30, 1'b0);
        i_arm = 1'b1; step(); i_arm = 1'b0;
        check("arm_ignored", 64'(o_count), 64'd1);
        send(32'h31, 1'b0);
        send(32'h32, 1'b0);
        i_trig = 1'b1; step(); i_trig = 1'b0;
        check("s3_state", 64'(o_state), 64'd3);
        check("s3_trig", 64'(o_trig_addr), 64'd3);
        send(32'h99, 1'b1);
        check("s3_retrig", 64'(o_state), 64'd3);
        check("s3_count", 64'(o_count), 64'd3);

        // Reset during post-trigger capture
        i_post_len = 4'd10;
        arm();
        send(32'h40, 1'b0);
        send(32'h41, 1'b1);
        send(32'h42, 1'b0);
        check("s5_post", 64'(o_state), 64'd2);
        i_sample = 32'h43; i_sample_valid = 1'b1; i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        step(); step(); step();
        i_sample_valid = 1'b0;
        check("s5_idle", 64'(o_state), 64'd0);

        // Reset during readout output phase
        i_post_len = 4'd1;
        arm();
        send(32'h50, 1'b1);
        send(32'h51, 1'b0);
        start_readout();
        i_rd_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (o_rd_valid) break;
            step();
        end
        check("s6_rdout", 64'(o_state), 64'd6);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        step();
        check("s6_idle", 64'(o_state), 64'd0);
        check("s6_valid", 64'(o_rd_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/postmortem_ctrl.md
POSTMORTEM_CTRL -- requirements
Module: postmortem_ctrl

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, meaning sample/RAM data width in bits.
REQ-002 The block SHALL have parameter RAM_DEPTH, default 50000, meaning number of RAM words (need not be a power of 2).
REQ-003 The block SHALL define AW = $clog2(RAM_DEPTH) and use it for every address and count port below.
REQ-004 The block SHALL have port i_clk, input, 1 bit, the single clock.
REQ-005 The block SHALL have port i_rst, input, 1 bit, reset (asynchronous, active-high).
REQ-006 The block SHALL have ports i_arm, i_trig and i_rd_req, each input, 1 bit, meaning arm capture, trigger event and start readout.
REQ-007 The block SHALL have ports i_sample_valid (input, 1 bit) and i_sample (input, DWIDTH bits), meaning the sample stream.
REQ-008 The block SHALL have port i_post_len, input, AW bits, meaning samples captured after the trigger.
REQ-009 The block SHALL have RAM write-port outputs o_wr_addr (AW), o_wr_ce (1), o_wr_we (1) and o_wr_din (DWIDTH), which drive the RAM s_ port.
REQ-010 The block SHALL have RAM read-port outputs o_rd_addr (AW) and o_rd_ce (1), plus input i_rd_dout (DWIDTH), which connect to the RAM m_ port; m_we is tied 0 outside the block.
REQ-011 The block SHALL have readout stream ports o_rd_valid (output, 1), o_rd_data (output, DWIDTH), o_rd_last (output, 1) and i_rd_ready (input, 1).
REQ-012 The block SHALL have status outputs o_state (3 bits), o_frozen (1), o_wrapped (1), o_trig_addr (AW) and o_count (AW+1).

Function
REQ-013 The state machine SHALL have states IDLE, ARMED, POST, FROZEN, RD_ISSUE, RD_WAIT and RD_OUT, and o_state SHALL carry their encodings 0 through 6.
REQ-014 IDLE SHALL move to ARMED on i_arm; on that transition wr_ptr, the sample count and o_wrapped SHALL clear.
REQ-015 In ARMED and POST, each cycle with i_sample_valid=1 SHALL assert o_wr_ce=o_wr_we=1 with o_wr_addr=wr_ptr and o_wr_din=i_sample, the same cycle (combinational pass-through).
REQ-016 After each write, wr_ptr SHALL advance, wrapping from RAM_DEPTH-1 to 0; the first wrap SHALL set o_wrapped.
REQ-017 o_count SHALL saturate at RAM_DEPTH.
REQ-018 ARMED SHALL move to POST on i_trig=1, latching o_trig_addr=wr_ptr; if a sample is written that same cycle, it is the trigger sample at o_trig_addr.
REQ-019 POST SHALL count valid samples and move to FROZEN when the count equals i_post_len, which is latched at trigger and clamped to RAM_DEPTH-1.
REQ-020 A latched post length of 0 SHALL cause FROZEN on the cycle after the trigger.
REQ-021 i_trig SHALL be ignored in all states other than ARMED.
REQ-022 o_wr_ce SHALL be 0 in every state other than ARMED and POST, so the buffer never changes while FROZEN or reading.
REQ-023 FROZEN SHALL assert o_frozen.
REQ-024 In FROZEN, i_arm SHALL restart capture (to ARMED, with pointers cleared); i_rd_req SHALL start readout; if both are high, i_arm SHALL win.
REQ-025 Readout SHALL begin at the oldest word: wr_ptr if o_wrapped, else 0.
REQ-026 Readout SHALL deliver o_count words in chronological order, with the read address wrapping at RAM_DEPTH-1.
REQ-027 RD_ISSUE SHALL pulse o_rd_ce for one cycle; RD_WAIT SHALL wait one cycle for RAM latency; RD_OUT SHALL register i_rd_dout into o_rd_data and hold o_rd_valid=1.
REQ-028 o_rd_data and o_rd_valid SHALL stay stable until i_rd_ready=1.
REQ-029 o_rd_last SHALL be 1 with the final word.
REQ-030 Readout throughput SHALL be at most one word per 3 cycles.
REQ-031 After the last accepted word, the block SHALL return to FROZEN, so the same buffer can be read repeatedly.
REQ-032 i_rd_req with o_count=0 SHALL be ignored.
REQ-033 i_arm SHALL be ignored in ARMED, POST and the readout states.

Reset
REQ-034 On i_rst=1, regardless of i_clk, the state SHALL become IDLE.
REQ-035 On i_rst=1, all pointers, counts, o_trig_addr, o_rd_data, o_wrapped and o_frozen SHALL become 0.
REQ-036 On i_rst=1, o_wr_ce, o_wr_we, o_rd_ce, o_rd_valid and o_rd_last SHALL become 0.
REQ-037 Reset asserted mid-capture or mid-readout SHALL abort the operation with no further RAM access; RAM contents are undefined to the block afterwards.

Configuration
REQ-038 Macro PM_TRIG_SYNC_EN, when defined, SHALL pass i_trig through a 2-flop synchronizer (reset 0) followed by a rising-edge detector, so a trigger acts 3 cycles after the i_trig edge.
REQ-039 Without PM_TRIG_SYNC_EN, i_trig SHALL be used as a synchronous level with no added latency.

Verification (RAM_DEPTH=16, DWIDTH=32, macro undefined)
REQ-040 Scenario: arm, 5 samples 0x1..0x5, trig on the 3rd, post_len=2 -> FROZEN, o_trig_addr=2, o_count=5, o_wrapped=0; readout gives 0x1..0x5 with o_rd_last on 0x5.
REQ-041 Scenario: arm, 20 samples 0x10..0x23, trig on 0x20, post_len=3 -> o_wrapped=1, o_count=16; readout starts at address 4 with 0x14 and ends 0x23.
REQ-042 Scenario: trig with post_len=0 and no sample that cycle -> FROZEN next cycle; a second i_trig pulse is ignored.
REQ-043 Scenario: i_rd_ready held 0 for 10 cycles during readout -> o_rd_valid and o_rd_data constant throughout; no word lost or duplicated.
REQ-044 Scenario: i_rst pulsed in POST and in RD_OUT -> next cycle IDLE, all outputs 0, no o_wr_ce after reset.
REQ-045 Scenario: PM_TRIG_SYNC_EN defined -> the trigger is latched 3 cycles after the i_trig rise, and o_trig_addr is advanced by the samples written in between.
